debug_uart_tx: RTL

UART transmitter for the debug path: pops bytes from the debug TX FIFO, which the debug controller fills with pipeline-state dumps, and serializes each byte onto the serial line as 8N1 (optional even parity). Produces the per-byte `dataSent` pulse that the debug controller counts to sequence its dump. Sits between the TX FIFO and the board `tx` pin.

---
 rtl/debug_uart_pkg.sv | 22 ++
 rtl/baud_tick_gen.sv | 35 +++
 rtl/debug_uart_tx.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/debug_uart_pkg.sv
// rtl/debug_uart_pkg.sv - shared FSM encoding and framing constants for the debug UART.
// FRAME_BITS follows the DEBUG_UART_TX_PARITY_EN build option.
package debug_uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  localparam int DEFAULT_DIVISOR       = 326;
  localparam int DEFAULT_TICKS_PER_BIT = 16;

`ifdef DEBUG_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - baud tick divider; one-cycle tick every DIVISOR clocks.
// A synchronous clear realigns the tick phase to the start of a frame.
module baud_tick_gen
  import debug_uart_pkg::*;
#(
  parameter int DIVISOR = DEFAULT_DIVISOR
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] DIV_MAX = 16'(DIVISOR - 1);

  logic [15:0] div_cnt_q;
  logic [15:0] div_cnt_d;

  always_comb begin
    tick      = (div_cnt_q == DIV_MAX);
    div_cnt_d = div_cnt_q + 16'd1;
    if (clear || tick) begin
      div_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt_q <= 16'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/debug_uart_tx.sv
// rtl/debug_uart_tx.sv - debug-path UART transmitter: pops the TX FIFO and sends 8N1 frames.
// Define DEBUG_UART_TX_PARITY_EN to insert an even-parity bit (11-bit frames).
module debug_uart_tx
  import debug_uart_pkg::*;
#(
  parameter int DIVISOR       = DEFAULT_DIVISOR,
  parameter int TICKS_PER_BIT = DEFAULT_TICKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] fifoData,
  input  logic       fifoEmpty,
  input  logic       holdOff,
  output logic       fifoRead,
  output logic       tx,
  output logic       busy,
  output logic       dataSent
);

  localparam logic [3:0] TICK_MAX = 4'(TICKS_PER_BIT - 1);

  uart_state_t state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_q, tx_d;
  logic        fifo_read_q, fifo_read_d;
  logic        busy_q, busy_d;
  logic        data_sent_q, data_sent_d;
  logic        div_clear;
  logic        tick;
  logic        bit_done;
`ifdef DEBUG_UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  baud_tick_gen #(
    .DIVISOR(DIVISOR)
  ) u_baud_tick_gen (
    .clock(clock),
    .reset(reset),
    .clear(div_clear),
    .tick (tick)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    tx_d        = tx_q;
    fifo_read_d = 1'b0;
    busy_d      = busy_q;
    data_sent_d = 1'b0;
    div_clear   = 1'b0;
`ifdef DEBUG_UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    bit_done    = tick && (tick_cnt_q == TICK_MAX);

    if (state_q != ST_IDLE && tick) begin
      tick_cnt_d = bit_done ? 4'd0 : tick_cnt_q + 4'd1;
    end

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifoEmpty && !holdOff) begin
          shift_d     = fifoData;
          fifo_read_d = 1'b1;
          div_clear   = 1'b1;
          tick_cnt_d  = 4'd0;
          bit_idx_d   = 3'd0;
          tx_d        = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_START;
`ifdef DEBUG_UART_TX_PARITY_EN
          parity_d    = ^fifoData;
`endif
        end
      end
      ST_START: begin
        if (bit_done) begin
          tx_d      = shift_q[0];
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        // tx always shows shift_q[0]; shifting right brings the next bit to the front
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
`ifdef DEBUG_UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            tx_d      = shift_q[1];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef DEBUG_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          tx_d        = 1'b1;
          data_sent_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= 8'd0;
      tick_cnt_q  <= 4'd0;
      bit_idx_q   <= 3'd0;
      tx_q        <= 1'b1;
      fifo_read_q <= 1'b0;
      busy_q      <= 1'b0;
      data_sent_q <= 1'b0;
`ifdef DEBUG_UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      fifo_read_q <= fifo_read_d;
      busy_q      <= busy_d;
      data_sent_q <= data_sent_d;
`ifdef DEBUG_UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign fifoRead = fifo_read_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign dataSent = data_sent_q;

endmodule
